// File: rtl/isa_pkg.sv
// Shared definitions for the ISA host initiator: op codes, FSM states,
// floating-bus value and the card's I/O register addresses.
package isa_pkg;

  localparam logic [1:0] ISA_OP_IOR  = 2'd0;
  localparam logic [1:0] ISA_OP_IOW  = 2'd1;
  localparam logic [1:0] ISA_OP_MEMR = 2'd2;
  localparam logic [1:0] ISA_OP_MEMW = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RESP,
    ST_WAIT
  } isa_state_e;

  localparam logic [7:0] ISA_FLOAT_BUS = 8'hFF;

  localparam logic [19:0] ISA_ADDR_CRTC_INDEX = 20'h003B4;
  localparam logic [19:0] ISA_ADDR_CRTC_DATA  = 20'h003B5;
  localparam logic [19:0] ISA_ADDR_MODE_CTRL  = 20'h003B8;
  localparam logic [19:0] ISA_ADDR_STATUS     = 20'h003BA;
  localparam logic [19:0] ISA_ADDR_CONFIG     = 20'h003BF;

  // Active-low strobe vector, bit index = op: {memw, memr, iow, ior}.
  function automatic logic [3:0] strobe_sel_l(input logic [1:0] op);
    return ~(4'b0001 << op);
  endfunction

  function automatic logic op_is_write(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/isa_cycle_timer.sv
// Loadable down-counter with zero flag; times the setup, strobe, hold and
// wait-state phases of an ISA cycle. Saturates at zero.
module isa_cycle_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset_l,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/isa_host_initiator.sv
// ISA bus initiator: turns a valid/ready request stream into timed ISA cycles.
// Define ISA_IOCHRDY_EN to honour bus_iochrdy wait states with a timeout abort.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// SETUP  | address (and write data) driven, strobe still high
// STROBE | selected strobe low for STROBE_CYCLES
// WAIT   | strobe held low while the card pulls iochrdy low (option only)
// HOLD   | strobe high, address/data still held
// RESP   | one-cycle rsp_valid pulse
module isa_host_initiator
  import isa_pkg::*;
#(
  parameter int ADDR_SETUP    = 2,
  parameter int STROBE_CYCLES = 6,
  parameter int HOLD_CYCLES   = 2,
  parameter int CHRDY_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [19:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [19:0] bus_a,
  output logic        bus_ior_l,
  output logic        bus_iow_l,
  output logic        bus_memr_l,
  output logic        bus_memw_l,
  output logic        bus_aen,
  output logic [7:0]  bus_d_out,
  output logic        bus_d_oe,
  input  logic [7:0]  bus_d_in,
  input  logic        bus_dir,
  input  logic        bus_iochrdy
);

  if (ADDR_SETUP < 1 || ADDR_SETUP > 15) begin : g_bad_setup
    $error("ADDR_SETUP must be 1..15");
  end
  if (STROBE_CYCLES < 2 || STROBE_CYCLES > 63) begin : g_bad_strobe
    $error("STROBE_CYCLES must be 2..63");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
    $error("HOLD_CYCLES must be 1..15");
  end
  if (CHRDY_TIMEOUT < 1 || CHRDY_TIMEOUT > 255) begin : g_bad_timeout
    $error("CHRDY_TIMEOUT must be 1..255");
  end

`ifdef ISA_IOCHRDY_EN
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] TOUT_LD = CNT_W'(CHRDY_TIMEOUT - 1);
`else
  localparam int CNT_W = 6;
  logic unused_chrdy;
  assign unused_chrdy = bus_iochrdy;
`endif
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(ADDR_SETUP - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);

  isa_state_e       state;
  logic [1:0]       op_q;
  logic [3:0]       strobe_l;
  logic             responded;
  logic             timeout_q;
  logic             accept;
  logic             rsp_fail;
  logic             t_load;
  logic             t_dec;
  logic             t_zero;
  logic [CNT_W-1:0] t_val;

  assign accept   = (state == ST_IDLE) && req_valid && req_ready;
  assign rsp_fail = timeout_q | (~op_is_write(op_q) & ~responded);

  assign {bus_memw_l, bus_memr_l, bus_iow_l, bus_ior_l} = strobe_l;
  assign bus_aen = 1'b0;

  always_comb begin
    t_load = 1'b0;
    t_val  = '0;
    t_dec  = (state == ST_SETUP) || (state == ST_STROBE) ||
             (state == ST_HOLD)  || (state == ST_WAIT);
    case (state)
      ST_IDLE:   if (accept) begin t_load = 1'b1; t_val = SETUP_LD; end
      ST_SETUP:  if (t_zero) begin t_load = 1'b1; t_val = STROBE_LD; end
      ST_STROBE: if (t_zero) begin
        t_load = 1'b1;
        t_val  = HOLD_LD;
`ifdef ISA_IOCHRDY_EN
        if (!bus_iochrdy) t_val = TOUT_LD;
`endif
      end
      ST_WAIT:   if (bus_iochrdy || t_zero) begin t_load = 1'b1; t_val = HOLD_LD; end
      default:   ;
    endcase
  end

  isa_cycle_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .reset_l  (reset_l),
    .load     (t_load),
    .dec      (t_dec),
    .load_val (t_val),
    .zero     (t_zero)
  );

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state     <= ST_IDLE;
      op_q      <= ISA_OP_IOR;
      strobe_l  <= 4'hF;
      bus_a     <= '0;
      bus_d_out <= '0;
      bus_d_oe  <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      responded <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          op_q      <= req_op;
          bus_a     <= req_addr;
          responded <= 1'b0;
          timeout_q <= 1'b0;
          req_ready <= 1'b0;
          if (op_is_write(req_op)) begin
            bus_d_oe  <= 1'b1;
            bus_d_out <= req_wdata;
          end
          state <= ST_SETUP;
        end
        ST_SETUP: if (t_zero) begin
          strobe_l <= strobe_sel_l(op_q);
          state    <= ST_STROBE;
        end
        ST_STROBE: if (t_zero) begin
`ifdef ISA_IOCHRDY_EN
          if (!bus_iochrdy) state <= ST_WAIT;
          else
`endif
          begin
            strobe_l <= 4'hF;
            if (!op_is_write(op_q)) begin
              rsp_rdata <= bus_d_in;
              responded <= bus_dir;
            end
            state <= ST_HOLD;
          end
        end
`ifdef ISA_IOCHRDY_EN
        ST_WAIT: if (bus_iochrdy) begin
          strobe_l <= 4'hF;
          if (!op_is_write(op_q)) begin
            rsp_rdata <= bus_d_in;
            responded <= bus_dir;
          end
          state <= ST_HOLD;
        end else if (t_zero) begin
          strobe_l  <= 4'hF;
          timeout_q <= 1'b1;
          state     <= ST_HOLD;
        end
`endif
        ST_HOLD: if (t_zero) begin
          bus_d_oe  <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err   <= rsp_fail;
          // A missing responder reads as a floating (pulled-up) bus.
          if (rsp_fail)               rsp_rdata <= ISA_FLOAT_BUS;
          else if (op_is_write(op_q)) rsp_rdata <= 8'h00;
          state <= ST_RESP;
        end
        ST_RESP: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
